reg_wb_arbiter: RTL

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

---
 rtl/reg_wb_arbiter_pkg.sv | 25 ++
 rtl/wb_ld_fifo.sv | 49 ++++
 rtl/reg_wb_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/reg_wb_arbiter_pkg.sv
// reg_wb_arbiter_pkg: shared register widths, hold-phase enum and the
// {th_id,addr} pending-bit index helper (arbiter + register file bank).
package reg_wb_arbiter_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 4;
    localparam int TH_W   = 2;

    // HS_HOLD: FIFO head has priority over the ALU.
    // HS_DRAIN: head already popped, alu_hold still shown for one cycle.
    typedef enum logic [1:0] {
        HS_IDLE  = 2'd0,
        HS_HOLD  = 2'd1,
        HS_DRAIN = 2'd2
    } hold_st_t;

    function automatic int unsigned pend_idx(
        input int unsigned th,
        input int unsigned addr,
        input int unsigned aw
    );
        return (th << aw) | addr;
    endfunction

endpackage

// File: rtl/wb_ld_fifo.sv
// wb_ld_fifo: load-return FIFO. Ports: clk, rst_n (async, active-low),
// push/din, pop/dout (head), full, empty, count. Push ignored when full.
module wb_ld_fifo #(
    parameter int width = 8,
    parameter int depth = 4,
    localparam int AW = (depth > 1) ? $clog2(depth) : 1,
    localparam int CW = $clog2(depth + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(depth));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (!do_push && do_pop) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: merges ALU writeback and buffered load returns onto one
// register-file write port, tracks pending load destinations.
// Ports: alu_* (no backpressure), ld_* (valid/ready), iss_* (mark pending),
// wena/w_th_id/waddr/wdata (1-cycle registered), pend_bits, alu_hold,
// waw_err / hold_err (sticky).
import reg_wb_arbiter_pkg::*;

module reg_wb_arbiter #(
    parameter int data_width   = DATA_W,
    parameter int addr_width   = ADDR_W,
    parameter int th_id_width  = TH_W,
    parameter int fifo_depth   = 4,
    parameter int starve_limit = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alu_valid,
    input  logic [th_id_width-1:0] alu_th_id,
    input  logic [addr_width-1:0]  alu_waddr,
    input  logic [data_width-1:0]  alu_wdata,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [th_id_width-1:0] ld_th_id,
    input  logic [addr_width-1:0]  ld_waddr,
    input  logic [data_width-1:0]  ld_wdata,
    input  logic                   iss_valid,
    input  logic [th_id_width-1:0] iss_th_id,
    input  logic [addr_width-1:0]  iss_waddr,
    output logic                   wena,
    output logic [th_id_width-1:0] w_th_id,
    output logic [addr_width-1:0]  waddr,
    output logic [data_width-1:0]  wdata,
    output logic [(1<<th_id_width)*(1<<addr_width)-1:0] pend_bits,
    output logic                   alu_hold,
    output logic                   waw_err,
    output logic                   hold_err
);

    localparam int ENT_W  = th_id_width + addr_width + data_width;
    localparam int PI_W   = th_id_width + addr_width;
    localparam int PEND_W = 1 << PI_W;
    localparam int SC_W   = $clog2(starve_limit + 1);
    localparam int FC_W   = $clog2(fifo_depth + 1);

    logic                   f_full;
    logic                   f_empty;
    logic                   f_push;
    logic                   f_pop;
    logic [FC_W-1:0]        f_count;
    logic [ENT_W-1:0]       f_din;
    logic [ENT_W-1:0]       f_dout;
    logic                   unused_cnt;
    logic [th_id_width-1:0] h_th;
    logic [addr_width-1:0]  h_addr;
    logic [data_width-1:0]  h_data;

    hold_st_t               hs_q;
    hold_st_t               hs_d;
    logic [SC_W-1:0]        sc_q;
    logic [SC_W-1:0]        sc_d;
    logic                   prio;
    logic                   take_fifo;
    logic                   take_alu;
    logic                   sel_v;
    logic [th_id_width-1:0] sel_th;
    logic [addr_width-1:0]  sel_addr;
    logic [data_width-1:0]  sel_data;
    logic [PI_W-1:0]        alu_idx;
    logic [PI_W-1:0]        clr_idx;
    logic [PI_W-1:0]        set_idx;
    logic [PEND_W-1:0]      pend_d;
    logic                   waw_d;
    logic                   herr_d;

    assign ld_ready   = ~f_full;
    assign f_push     = ld_valid & ld_ready;
    assign f_pop      = take_fifo;
    assign f_din      = {ld_th_id, ld_waddr, ld_wdata};
    assign {h_th, h_addr, h_data} = f_dout;
    assign unused_cnt = ^f_count;

    wb_ld_fifo #(
        .width (ENT_W),
        .depth (fifo_depth)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (f_push),
        .pop   (f_pop),
        .din   (f_din),
        .dout  (f_dout),
        .full  (f_full),
        .empty (f_empty),
        .count (f_count)
    );

    assign alu_hold  = (hs_q != HS_IDLE);
    assign prio      = (hs_q == HS_HOLD) && !f_empty;
    assign take_fifo = prio || (!alu_valid && !f_empty);
    assign take_alu  = alu_valid && !prio;
    assign sel_v     = take_fifo || take_alu;
    assign sel_th    = take_alu ? alu_th_id : h_th;
    assign sel_addr  = take_alu ? alu_waddr : h_addr;
    assign sel_data  = take_alu ? alu_wdata : h_data;

    // A head that drains in the same cycle the limit is hit needs no hold.
    always_comb begin
        hs_d = hs_q;
        unique case (hs_q)
            HS_IDLE:  if (sc_q == SC_W'(starve_limit) && !take_fifo)
                          hs_d = HS_HOLD;
            HS_HOLD:  if (take_fifo) hs_d = HS_DRAIN;
            HS_DRAIN: hs_d = HS_IDLE;
            default:  hs_d = HS_IDLE;
        endcase
    end

    always_comb begin
        alu_idx = PI_W'(pend_idx(32'(alu_th_id), 32'(alu_waddr), addr_width));
        clr_idx = PI_W'(pend_idx(32'(h_th), 32'(h_addr), addr_width));
        set_idx = PI_W'(pend_idx(32'(iss_th_id), 32'(iss_waddr), addr_width));
        pend_d  = pend_bits;
        if (take_fifo) pend_d[clr_idx] = 1'b0;
        // set after clear: a same-cycle issue keeps the bit pending
        if (iss_valid && iss_waddr != '0) pend_d[set_idx] = 1'b1;
        waw_d  = waw_err | (take_alu & pend_bits[alu_idx]);
        herr_d = hold_err | (alu_valid & prio);
        if (take_fifo || f_empty)
            sc_d = '0;
        else if (sc_q != SC_W'(starve_limit))
            sc_d = sc_q + SC_W'(1);
        else
            sc_d = sc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q      <= HS_IDLE;
            sc_q      <= '0;
            pend_bits <= '0;
            waw_err   <= 1'b0;
            hold_err  <= 1'b0;
            wena      <= 1'b0;
            w_th_id   <= '0;
            waddr     <= '0;
            wdata     <= '0;
        end else begin
            hs_q      <= hs_d;
            sc_q      <= sc_d;
            pend_bits <= pend_d;
            waw_err   <= waw_d;
            hold_err  <= herr_d;
            // register 0 writes are consumed but never reach the regfile
            wena      <= sel_v && (sel_addr != '0);
            if (sel_v && sel_addr != '0) begin
                w_th_id <= sel_th;
                waddr   <= sel_addr;
                wdata   <= sel_data;
            end
        end
    end

endmodule
